// File: rtl/weight_dma_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_dma_loader_pkg
// Description : Shared definitions for the Conv2 weight/bias DMA loader:
//               lane geometry, loader buffer selects, FSM state and lane
//               unpack mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package weight_dma_loader_pkg;

    // Loader lanes; at least 6 are needed to hold the six bias halves.
    localparam int unsigned K_CHANNELS   = 8;
    localparam int unsigned LANE_W       = 32;
    localparam int unsigned WEIGHT_LANES = 6;
    localparam int unsigned BIAS_WORDS   = 3;

    localparam logic [1:0] SEL_WEIGHT = 2'd1;
    localparam logic [1:0] SEL_BIAS   = 2'd2;

    // Layer that needs no weights: acknowledged at once, pointers cleared.
    localparam logic [3:0] LAYER_NO_WEIGHTS = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_RD   = 3'd1,
        ST_W_WAIT = 3'd2,
        ST_B_RD   = 3'd3,
        ST_B_WAIT = 3'd4,
        ST_ACK    = 3'd5
    } dma_state_t;

    typedef enum logic [1:0] {
        UNPACK_WEIGHT = 2'd0,
        UNPACK_BIAS0  = 2'd1,
        UNPACK_BIAS1  = 2'd2,
        UNPACK_BIAS2  = 2'd3
    } unpack_mode_t;

    // Conv2 groups occupy layer IDs 2 .. num_groups+1.
    function automatic logic is_conv2_layer(input logic [3:0] id, input int unsigned num_groups);
        return (id >= 4'd2) && ({28'd0, id} <= 32'(num_groups + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_dma_loader_unpack.sv
`default_nettype none
// ============================================================================
// Module      : weight_lane_unpack
// Description : Purely combinational spreading of one 64-bit memory word
//               onto the loader lanes. Weight mode places bytes 0..5 into
//               the low byte of lanes 0..5; bias mode j places the low/high
//               32-bit halves into lanes 2j/2j+1. All other bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_lane_unpack
    import weight_dma_loader_pkg::*;
(
    input  logic [63:0]                  data_i,
    input  unpack_mode_t                 mode_i,
    output logic [K_CHANNELS*LANE_W-1:0] lanes_o
);

    // Route the selected byte/half-word fields to their lanes.
    always_comb begin
        lanes_o = '0;
        case (mode_i)
            UNPACK_WEIGHT: begin
                for (int k = 0; k < int'(WEIGHT_LANES); k++) begin
                    lanes_o[k*LANE_W +: 8] = data_i[k*8 +: 8];
                end
            end
            UNPACK_BIAS0: begin
                lanes_o[0*LANE_W +: LANE_W] = data_i[31:0];
                lanes_o[1*LANE_W +: LANE_W] = data_i[63:32];
            end
            UNPACK_BIAS1: begin
                lanes_o[2*LANE_W +: LANE_W] = data_i[31:0];
                lanes_o[3*LANE_W +: LANE_W] = data_i[63:32];
            end
            UNPACK_BIAS2: begin
                lanes_o[4*LANE_W +: LANE_W] = data_i[31:0];
                lanes_o[5*LANE_W +: LANE_W] = data_i[63:32];
            end
            default: lanes_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/weight_dma_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_dma_loader
// Description : Fetches one Conv2 group of weight lines and its three bias
//               words from external memory (one read outstanding at a time)
//               and writes them into the weight/bias loader buffers, then
//               handshakes completion back to the host controller.
//               Optional: define WEIGHT_DMA_PERF_EN to add perf_cycles_o, a
//               saturating count of cycles spent transferring.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_dma_loader
    import weight_dma_loader_pkg::*;
#(
    parameter logic [31:0] W_BASE           = 32'h0000_0000,
    parameter logic [31:0] B_BASE           = 32'h0000_1000,
    parameter int unsigned WLINES_PER_GROUP = 150,
    parameter int unsigned NUM_GROUPS       = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_async_n_i,
    input  logic                         req_load_i,
    input  logic [3:0]                   layer_id_i,
    output logic                         weight_loaded_o,
    output logic                         mem_rd_en_o,
    output logic [31:0]                  mem_rd_addr_o,
    input  logic [63:0]                  mem_rd_data_i,
    input  logic                         mem_rd_valid_i,
    output logic [1:0]                   loader_sel_o,
    output logic                         loader_wr_en_o,
    output logic [31:0]                  loader_wr_addr_o,
    output logic [K_CHANNELS*LANE_W-1:0] loader_wr_data_o,
    output logic                         err_layer_o
`ifdef WEIGHT_DMA_PERF_EN
    ,
    output logic [31:0]                  perf_cycles_o
`endif
);

    localparam logic [31:0] W_PTR_LAST = 32'(NUM_GROUPS * WLINES_PER_GROUP - 1);
    localparam logic [31:0] B_PTR_LAST = 32'(NUM_GROUPS * BIAS_WORDS - 1);
    localparam logic [31:0] LINE_LAST  = 32'(WLINES_PER_GROUP - 1);
    localparam logic [1:0]  BIAS_LAST  = 2'(BIAS_WORDS - 1);

    dma_state_t                  state_q, state_d;
    logic [31:0]                 w_ptr_q, w_ptr_d;
    logic [31:0]                 b_ptr_q, b_ptr_d;
    logic [31:0]                 line_idx_q, line_idx_d;
    logic [1:0]                  bias_idx_q, bias_idx_d;
    logic [K_CHANNELS*LANE_W-1:0] bias_acc_q, bias_acc_d;

    logic                        weight_loaded_q, weight_loaded_d;
    logic                        mem_rd_en_q, mem_rd_en_d;
    logic [31:0]                 mem_rd_addr_q, mem_rd_addr_d;
    logic [1:0]                  loader_sel_q, loader_sel_d;
    logic                        loader_wr_en_q, loader_wr_en_d;
    logic [31:0]                 loader_wr_addr_q, loader_wr_addr_d;
    logic [K_CHANNELS*LANE_W-1:0] loader_wr_data_q, loader_wr_data_d;
    logic                        err_layer_q, err_layer_d;

    unpack_mode_t                unpack_mode;
    logic [K_CHANNELS*LANE_W-1:0] unpacked_lanes;

    // Weight layout while fetching weights, otherwise the current bias word slot.
    always_comb begin
        unpack_mode = UNPACK_WEIGHT;
        if (state_q == ST_B_WAIT) begin
            case (bias_idx_q)
                2'd0:    unpack_mode = UNPACK_BIAS0;
                2'd1:    unpack_mode = UNPACK_BIAS1;
                default: unpack_mode = UNPACK_BIAS2;
            endcase
        end
    end

    weight_lane_unpack u_unpack (
        .data_i  (mem_rd_data_i),
        .mode_i  (unpack_mode),
        .lanes_o (unpacked_lanes)
    );

    // Next-state and registered-output logic; reads and writes live in
    // disjoint states so the two strobes can never coincide.
    always_comb begin
        state_d          = state_q;
        w_ptr_d          = w_ptr_q;
        b_ptr_d          = b_ptr_q;
        line_idx_d       = line_idx_q;
        bias_idx_d       = bias_idx_q;
        bias_acc_d       = bias_acc_q;
        weight_loaded_d  = weight_loaded_q;
        mem_rd_en_d      = 1'b0;
        mem_rd_addr_d    = mem_rd_addr_q;
        loader_sel_d     = loader_sel_q;
        loader_wr_en_d   = 1'b0;
        loader_wr_addr_d = loader_wr_addr_q;
        loader_wr_data_d = loader_wr_data_q;
        err_layer_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_load_i) begin
                    if (layer_id_i == LAYER_NO_WEIGHTS) begin
                        w_ptr_d         = '0;
                        b_ptr_d         = '0;
                        weight_loaded_d = 1'b1;
                        state_d         = ST_ACK;
                    end else if (is_conv2_layer(layer_id_i, NUM_GROUPS)) begin
                        line_idx_d = '0;
                        bias_idx_d = '0;
                        bias_acc_d = '0;
                        state_d    = ST_W_RD;
                    end else begin
                        err_layer_d     = 1'b1;
                        weight_loaded_d = 1'b1;
                        state_d         = ST_ACK;
                    end
                end
            end
            ST_W_RD: begin
                mem_rd_en_d   = 1'b1;
                mem_rd_addr_d = W_BASE + w_ptr_q;
                state_d       = ST_W_WAIT;
            end
            ST_W_WAIT: begin
                if (mem_rd_valid_i) begin
                    loader_wr_en_d   = 1'b1;
                    loader_sel_d     = SEL_WEIGHT;
                    loader_wr_addr_d = line_idx_q;
                    loader_wr_data_d = unpacked_lanes;
                    w_ptr_d          = (w_ptr_q == W_PTR_LAST) ? '0 : w_ptr_q + 32'd1;
                    if (line_idx_q == LINE_LAST) begin
                        line_idx_d = '0;
                        state_d    = ST_B_RD;
                    end else begin
                        line_idx_d = line_idx_q + 32'd1;
                        state_d    = ST_W_RD;
                    end
                end
            end
            ST_B_RD: begin
                mem_rd_en_d   = 1'b1;
                mem_rd_addr_d = B_BASE + b_ptr_q;
                state_d       = ST_B_WAIT;
            end
            ST_B_WAIT: begin
                if (mem_rd_valid_i) begin
                    bias_acc_d = bias_acc_q | unpacked_lanes;
                    b_ptr_d    = (b_ptr_q == B_PTR_LAST) ? '0 : b_ptr_q + 32'd1;
                    if (bias_idx_q == BIAS_LAST) begin
                        bias_idx_d       = '0;
                        loader_wr_en_d   = 1'b1;
                        loader_sel_d     = SEL_BIAS;
                        loader_wr_addr_d = '0;
                        loader_wr_data_d = bias_acc_q | unpacked_lanes;
                        weight_loaded_d  = 1'b1;
                        state_d          = ST_ACK;
                    end else begin
                        bias_idx_d = bias_idx_q + 2'd1;
                        state_d    = ST_B_RD;
                    end
                end
            end
            ST_ACK: begin
                // Stay acknowledged while the request is still held.
                if (!req_load_i) begin
                    weight_loaded_d = 1'b0;
                    state_d         = ST_IDLE;
                end else begin
                    weight_loaded_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointers and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q          <= ST_IDLE;
            w_ptr_q          <= '0;
            b_ptr_q          <= '0;
            line_idx_q       <= '0;
            bias_idx_q       <= '0;
            bias_acc_q       <= '0;
            weight_loaded_q  <= 1'b0;
            mem_rd_en_q      <= 1'b0;
            mem_rd_addr_q    <= '0;
            loader_sel_q     <= '0;
            loader_wr_en_q   <= 1'b0;
            loader_wr_addr_q <= '0;
            loader_wr_data_q <= '0;
            err_layer_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            w_ptr_q          <= w_ptr_d;
            b_ptr_q          <= b_ptr_d;
            line_idx_q       <= line_idx_d;
            bias_idx_q       <= bias_idx_d;
            bias_acc_q       <= bias_acc_d;
            weight_loaded_q  <= weight_loaded_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_rd_addr_q    <= mem_rd_addr_d;
            loader_sel_q     <= loader_sel_d;
            loader_wr_en_q   <= loader_wr_en_d;
            loader_wr_addr_q <= loader_wr_addr_d;
            loader_wr_data_q <= loader_wr_data_d;
            err_layer_q      <= err_layer_d;
        end
    end

    assign weight_loaded_o  = weight_loaded_q;
    assign mem_rd_en_o      = mem_rd_en_q;
    assign mem_rd_addr_o    = mem_rd_addr_q;
    assign loader_sel_o     = loader_sel_q;
    assign loader_wr_en_o   = loader_wr_en_q;
    assign loader_wr_addr_o = loader_wr_addr_q;
    assign loader_wr_data_o = loader_wr_data_q;
    assign err_layer_o      = err_layer_q;

`ifdef WEIGHT_DMA_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;

    // Count busy (transferring) cycles, holding at all-ones.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        if ((state_q != ST_IDLE) && (state_q != ST_ACK) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            perf_cycles_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_dma_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_dma_loader
// Description : Scoreboard bench for weight_dma_loader: requests issue
//               expected reads/writes from a group-level reference model; a
//               monitor pops and compares whenever the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_dma_loader;
    import weight_dma_loader_pkg::*;

    localparam logic [31:0] W_BASE  = 32'h0000_0000;
    localparam logic [31:0] B_BASE  = 32'h0000_1000;
    localparam int          WLINES  = 150;
    localparam int          NGROUPS = 3;
    localparam int          DW      = K_CHANNELS * LANE_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req = 1'b0;
    logic [3:0]    layer_id = 4'd0;
    logic [63:0]   rd_data = '0;
    logic          rd_valid = 1'b0;
    logic          weight_loaded_o, mem_rd_en_o, loader_wr_en_o, err_layer_o;
    logic [31:0]   mem_rd_addr_o, loader_wr_addr_o;
    logic [1:0]    loader_sel_o;
    logic [DW-1:0] loader_wr_data_o;
`ifdef WEIGHT_DMA_PERF_EN
    logic [31:0]   perf_cycles_o;
`endif

    always #5 clk = ~clk;

    weight_dma_loader #(
        .W_BASE(W_BASE), .B_BASE(B_BASE),
        .WLINES_PER_GROUP(WLINES), .NUM_GROUPS(NGROUPS)
    ) dut (
        .clk_i           (clk),
        .rst_async_n_i   (rst_n),
        .req_load_i      (req),
        .layer_id_i      (layer_id),
        .weight_loaded_o (weight_loaded_o),
        .mem_rd_en_o     (mem_rd_en_o),
        .mem_rd_addr_o   (mem_rd_addr_o),
        .mem_rd_data_i   (rd_data),
        .mem_rd_valid_i  (rd_valid),
        .loader_sel_o    (loader_sel_o),
        .loader_wr_en_o  (loader_wr_en_o),
        .loader_wr_addr_o(loader_wr_addr_o),
        .loader_wr_data_o(loader_wr_data_o),
        .err_layer_o     (err_layer_o)
`ifdef WEIGHT_DMA_PERF_EN
        ,
        .perf_cycles_o   (perf_cycles_o)
`endif
    );

    typedef struct {
        logic [1:0]    sel;
        logic [31:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [31:0]   exp_rd[$];
    int            checks = 0;
    int            errors = 0;
    int            wr_seen = 0;
    int            err_seen = 0;
    int            m_wptr = 0;
    int            m_bptr = 0;
    logic          spurious_en = 1'b0;
    logic [DW-1:0] last_bias = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event-missing expected event-present", name);
    endtask

    // External memory contents: low half is the word address, high half a hash.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {(a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3, a};
    endfunction

    function automatic logic [DW-1:0] weight_lanes(input logic [63:0] w);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < 6; k++) v[k*32 +: 8] = w[k*8 +: 8];
        return v;
    endfunction

    // Reference model: the whole transaction list for one request.
    task automatic model_push(input logic [3:0] id);
        logic [31:0]   a;
        logic [63:0]   w;
        logic [DW-1:0] bias;
        wr_t           e;
        if (id == 4'd1) begin
            m_wptr = 0;
            m_bptr = 0;
        end else if (id >= 4'd2 && id <= 4'd4) begin
            for (int i = 0; i < WLINES; i++) begin
                a = W_BASE + 32'(m_wptr);
                exp_rd.push_back(a);
                e.sel = 2'd1; e.addr = 32'(i); e.data = weight_lanes(mem_word(a));
                exp_wr.push_back(e);
                m_wptr = (m_wptr + 1) % (WLINES * NGROUPS);
            end
            bias = '0;
            for (int j = 0; j < 3; j++) begin
                a = B_BASE + 32'(m_bptr);
                exp_rd.push_back(a);
                w = mem_word(a);
                bias[(2*j)*32 +: 32]   = w[31:0];
                bias[(2*j+1)*32 +: 32] = w[63:32];
                m_bptr = (m_bptr + 1) % (3 * NGROUPS);
            end
            e.sel = 2'd2; e.addr = 32'd0; e.data = bias;
            exp_wr.push_back(e);
        end
    endtask

    // Monitor: compares every DUT strobe against the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rd_en_o) begin
                    check("rd_wr_exclusive", DW'(loader_wr_en_o), DW'(0));
                    if (exp_rd.size() == 0) fail_now("unexpected_read");
                    else check("rd_addr", DW'(mem_rd_addr_o), DW'(exp_rd.pop_front()));
                end
                if (loader_wr_en_o) begin
                    wr_seen++;
                    if (loader_sel_o == 2'd2) last_bias = loader_wr_data_o;
                    if (exp_wr.size() == 0) fail_now("unexpected_write");
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_sel", DW'(loader_sel_o), DW'(e.sel));
                        check("wr_addr", DW'(loader_wr_addr_o), DW'(e.addr));
                        check("wr_data", loader_wr_data_o, e.data);
                    end
                end
                if (err_layer_o) err_seen++;
            end
        end
    end

    // Memory responder: random 0..7 cycle latency, spurious valids when idle.
    initial begin
        logic [31:0] a;
        int          d;
        bit          abort;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (rst_n && mem_rd_en_o) begin
                a = mem_rd_addr_o;
                d = int'($urandom_range(0, 7));
                abort = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    check("one_outstanding", DW'(mem_rd_en_o), DW'(0));
                end
                if (!abort) begin
                    rd_valid = 1'b1;
                    rd_data  = mem_word(a);
                end
            end else if (rst_n && spurious_en && $urandom_range(0, 3) == 0) begin
                rd_valid = 1'b1;
                rd_data  = {$urandom(), $urandom()};
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_weight_loaded"}, DW'(weight_loaded_o), DW'(0));
        check({tag, "_rd_en"}, DW'(mem_rd_en_o), DW'(0));
        check({tag, "_rd_addr"}, DW'(mem_rd_addr_o), DW'(0));
        check({tag, "_sel"}, DW'(loader_sel_o), DW'(0));
        check({tag, "_wr_en"}, DW'(loader_wr_en_o), DW'(0));
        check({tag, "_wr_addr"}, DW'(loader_wr_addr_o), DW'(0));
        check({tag, "_wr_data"}, loader_wr_data_o, DW'(0));
        check({tag, "_err"}, DW'(err_layer_o), DW'(0));
    endtask

    task automatic do_request(input logic [3:0] id, input bit drop_early);
        int err_before;
        int n;
        bit got;
        bit bad;
        bad = !(id >= 4'd1 && id <= 4'd4);
        model_push(id);
        spurious_en = 1'b0;
        repeat (2) @(negedge clk);
        err_before = err_seen;
        layer_id = id;
        req = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 20000) begin
            @(negedge clk);
            n++;
            if (weight_loaded_o) got = 1'b1;
            else if (drop_early && n == 3) req = 1'b0;
        end
        if (!got) begin
            fail_now("ack_timeout");
            req = 1'b0;
        end else if (drop_early) begin
            @(negedge clk);
            check("ack_one_cycle", DW'(weight_loaded_o), DW'(0));
        end else begin
            spurious_en = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                check("ack_held", DW'(weight_loaded_o), DW'(1));
            end
            req = 1'b0;
            @(negedge clk);
            check("ack_release", DW'(weight_loaded_o), DW'(0));
        end
        spurious_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reads_drained", DW'(exp_rd.size()), DW'(0));
        check("writes_drained", DW'(exp_wr.size()), DW'(0));
        check("err_pulses", DW'(err_seen - err_before), DW'(bad ? 1 : 0));
    endtask

    initial begin
        logic [3:0]  ids [8];
        logic [3:0]  id;
        logic [63:0] w5;
        int          base;
        int          n;
        ids = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd15};

        #1 rst_n = 1'b0;
        #2 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_request(4'd1, 1'b0);
        do_request(4'd2, 1'b0);
        do_request(4'd3, 1'b1);
        w5 = mem_word(B_BASE + 32'd5);
        check("bias_lane5", DW'(last_bias[5*32 +: 32]), DW'(w5[63:32]));
        do_request(4'd7, 1'b0);
        do_request(4'd4, 1'b0);
        do_request(4'd2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            id = ids[$urandom_range(0, 7)];
            do_request(id, (id >= 4'd2 && id <= 4'd4) && ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of a weight group.
        model_push(4'd2);
        spurious_en = 1'b0;
        repeat (2) @(negedge clk);
        base = wr_seen;
        layer_id = 4'd2;
        req = 1'b1;
        n = 0;
        while (wr_seen < base + 73 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (wr_seen < base + 73) fail_now("line73_timeout");
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        req = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        m_wptr = 0;
        m_bptr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_request(4'd2, 1'b0);
        do_request(4'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
